mem_phase_sched: RTL and testbench
==================================

Name: mem_phase_sched

Overview:
- Phase sequencer and memory arbiter for the 16-bit CPU core.
- Steps the core through fetch, memory and writeback phases, and owns the single-port 4K x 16 program/data RAM.
- Multiplexes RAM address, write enable and write data between instruction fetch (pc), load/store (result/ra) and an external program loader.
- Generates the phase code and the ir/pc/regfile strobes the datapath consumes.

Parameters:
RD_LAT, 1, RAM read latency in cycles (1..7); fetch and load phases are held this many cycles.
AW, 12, RAM address width.
DW, 16, data/instruction width.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
run  input  1  leave IDLE and start fetching at pc
halt_req  input  1  stop after current instruction's WB
instr  input  DW  current instruction register contents
result  input  DW  ALU result; [AW-1:0] used as load/store address
ra  input  DW  store data
pc  input  AW  program counter
ldr_req  input  1  loader requests a RAM access
ldr_we  input  1  loader access is a write
ldr_addr  input  AW  loader address
ldr_data  input  DW  loader write data
phase  output  3  000 IF, 001 MEM, 010 WB, 100 IDLE
address  output  AW  RAM address
wren  output  1  RAM write enable
data  output  DW  RAM write data
ir_load  output  1  capture RAM q into instr register
pc_inc  output  1  advance pc
rf_we  output  1  register-file write strobe
ldr_ack  output  1  loader access performed this cycle
halted  output  1  high in IDLE

Behaviour:
- Reset (rst=1 at a clock edge) puts the block in IDLE with wait counter 0. Registered outputs after reset: phase=100, halted=1.
- While rst=1, wren, ldr_ack, ir_load, pc_inc and rf_we are forced 0 combinationally, including mid-store.
- States and transitions:
  - IDLE: goes to IF when run=1.
  - IF: goes to MEM after RD_LAT cycles.
  - MEM: goes to WB after its hold time.
  - WB: single cycle; goes to IDLE if halt_req=1 in that cycle, else to IF.
- Instruction class from instr[15:14]: 00 load, 01 store, others non-memory.
- Wait counter: 3-bit. Cleared on entry to IF and MEM; increments each held cycle.
  - IF exits when counter == RD_LAT-1.
  - MEM for a load exits when counter == RD_LAT-1.
  - MEM for a store or non-memory instruction is 1 cycle.
- Bus mux (combinational from state and inputs):
  - IF: address=pc, wren=0, data=0.
  - MEM load: address=result[AW-1:0], wren=0, data=0.
  - MEM store: address=result[AW-1:0], wren=1, data=ra. wren is high exactly 1 cycle.
  - MEM non-memory: address=pc, wren=0, data=0.
  - IDLE or WB with ldr_req=1: address=ldr_addr, wren=ldr_we, data=ldr_data, ldr_ack=1.
  - IDLE or WB with ldr_req=0: address=pc, wren=0, data=0.
- Loader arbitration: CPU has priority. ldr_ack is 0 in IF and MEM, so the loader holds its request.
  - Worst-case wait is 2*RD_LAT+1 cycles.
  - One loader access per acked cycle; back-to-back in IDLE.
- Strobes:
  - ir_load=1 on the last IF cycle.
  - pc_inc=1 in WB.
  - rf_we=1 in WB unless the instruction is a store.
- run=1 and ldr_req=1 in the same IDLE cycle: the loader is acked that cycle and IF starts next cycle.
- run is ignored outside IDLE. halt_req is only sampled in WB.
- Counter never wraps for legal RD_LAT. RD_LAT=0 is illegal (flagged by an assertion).

Test Plan:
- Reset then run=1 pulse, instr=16'h8000, RD_LAT=1 -> phase sequence 100,000,001,010,000. address=pc in IF. ir_load and pc_inc each 1 cycle. rf_we=1 in WB.
- Store: instr=16'h4000, result=16'h0123, ra=16'hBEEF -> in MEM, address=12'h123, data=16'hBEEF, wren=1 for exactly 1 cycle. rf_we=0 in WB.
- Load with RD_LAT=3: instr=16'h0000, result=16'h0FFF -> IF held 3 cycles, MEM held 3 cycles with address=12'hFFF and wren=0, then WB.
- Loader in IDLE: ldr_req=1, ldr_we=1, ldr_addr=0..3, data=16'hA5A0..A5A3 -> 4 consecutive acks with wren=1. A ldr_req raised during IF is acked only in WB.
- halt_req=1 during MEM -> WB completes (pc_inc=1), then IDLE with halted=1. A later run=1 resumes at IF.
- rst=1 asserted in the store MEM cycle -> wren=0 that cycle. Next cycle phase=100 and no RAM write occurred.

Source files
------------

// File: rtl/mem_phase_sched.sv
// Phase sequencer (IDLE/IF/MEM/WB) for the 16-bit core and arbiter for its single-port RAM.
// The CPU owns the RAM in IF and MEM; the external loader is served in IDLE and WB.
module mem_phase_sched #(
   parameter int RD_LAT = 1,
   parameter int AW     = 12,
   parameter int DW     = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          run,
   input  logic          halt_req,
   input  logic [DW-1:0] instr,
   input  logic [DW-1:0] result,
   input  logic [DW-1:0] ra,
   input  logic [AW-1:0] pc,
   input  logic          ldr_req,
   input  logic          ldr_we,
   input  logic [AW-1:0] ldr_addr,
   input  logic [DW-1:0] ldr_data,
   output logic [2:0]    phase,
   output logic [AW-1:0] address,
   output logic          wren,
   output logic [DW-1:0] data,
   output logic          ir_load,
   output logic          pc_inc,
   output logic          rf_we,
   output logic          ldr_ack,
   output logic          halted
);

   // State encodings double as the phase code seen by the datapath.
   typedef enum logic [2:0] {
      S_IF   = 3'b000,
      S_MEM  = 3'b001,
      S_WB   = 3'b010,
      S_IDLE = 3'b100
   } state_t;

   localparam logic [2:0] LAST_CNT = 3'(RD_LAT - 1);

   generate
      if (RD_LAT < 1 || RD_LAT > 7) begin : g_badRdLat
         $error("mem_phase_sched: RD_LAT must be in 1..7");
      end
   endgenerate

   state_t     r_state;
   logic [2:0] r_cnt;

   logic w_isLoad;
   logic w_isStore;
   logic w_cntDone;
   logic w_unused;

   assign w_isLoad  = (instr[DW-1:DW-2] == 2'b00);
   assign w_isStore = (instr[DW-1:DW-2] == 2'b01);
   assign w_cntDone = (r_cnt == LAST_CNT);
   assign w_unused  = ^{instr[DW-3:0], result[DW-1:AW]};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (run) begin
                  r_state <= S_IF;
                  r_cnt   <= '0;
               end
            end
            S_IF: begin
               if (w_cntDone) begin
                  r_state <= S_MEM;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 3'd1;
               end
            end
            // Only loads wait out the read latency; stores and ALU ops spend one cycle here.
            S_MEM: begin
               if (!w_isLoad || w_cntDone) begin
                  r_state <= S_WB;
               end else begin
                  r_cnt <= r_cnt + 3'd1;
               end
            end
            S_WB: begin
               r_cnt   <= '0;
               r_state <= halt_req ? S_IDLE : S_IF;
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   always_comb begin
      address = pc;
      wren    = 1'b0;
      data    = '0;
      ldr_ack = 1'b0;
      case (r_state)
         S_MEM: begin
            if (w_isLoad) begin
               address = result[AW-1:0];
            end else if (w_isStore) begin
               address = result[AW-1:0];
               wren    = 1'b1;
               data    = ra;
            end
         end
         S_IDLE, S_WB: begin
            if (ldr_req) begin
               address = ldr_addr;
               wren    = ldr_we;
               data    = ldr_data;
               ldr_ack = 1'b1;
            end
         end
         default: begin
         end
      endcase
      // A reset landing mid-store must not let the write reach the RAM.
      if (rst) begin
         wren    = 1'b0;
         ldr_ack = 1'b0;
      end
   end

   assign ir_load = !rst && (r_state == S_IF) && w_cntDone;
   assign pc_inc  = !rst && (r_state == S_WB);
   assign rf_we   = !rst && (r_state == S_WB) && !w_isStore;
   assign phase   = r_state;
   assign halted  = (r_state == S_IDLE);

endmodule

// File: tb/tb_mem_phase_sched.sv
// Self-checking bench for mem_phase_sched: two instances (RD_LAT=1 and RD_LAT=3) share stimulus,
// and each test checks one of them against a phase-plan reference model.
module tb_mem_phase_sched;

   typedef struct packed {
      logic [2:0]  phase;
      logic [11:0] address;
      logic        wren;
      logic [15:0] data;
      logic        irLoad;
      logic        pcInc;
      logic        rfWe;
      logic        ldrAck;
      logic        halted;
   } outs_t;

   typedef struct {
      int ph;
      int idx;
      bit lastIf;
   } step_t;

   localparam int PH_IF = 0, PH_MEM = 1, PH_WB = 2, PH_IDLE = 4;

   logic        clk, rst, run, halt_req, ldr_req, ldr_we;
   logic [15:0] instr, result, ra, ldr_data;
   logic [11:0] pc, ldr_addr;

   logic [2:0]  phase1, phase3;
   logic [11:0] address1, address3;
   logic [15:0] data1, data3;
   logic        wren1, irLoad1, pcInc1, rfWe1, ldrAck1, halted1;
   logic        wren3, irLoad3, pcInc3, rfWe3, ldrAck3, halted3;
   outs_t       obs1, obs3;

   int checks = 0;
   int errors = 0;

   logic [15:0] pInstr [4];
   logic [15:0] pResult [4];
   logic [15:0] pRa [4];
   logic [11:0] pPc [4];
   int          ldrMode;
   int          haltMode;
   outs_t       obsQ [$];
   outs_t       expQ [$];

   mem_phase_sched #(.RD_LAT(1), .AW(12), .DW(16)) dut1 (
      .clk(clk), .rst(rst), .run(run), .halt_req(halt_req), .instr(instr), .result(result),
      .ra(ra), .pc(pc), .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr),
      .ldr_data(ldr_data), .phase(phase1), .address(address1), .wren(wren1), .data(data1),
      .ir_load(irLoad1), .pc_inc(pcInc1), .rf_we(rfWe1), .ldr_ack(ldrAck1), .halted(halted1)
   );

   mem_phase_sched #(.RD_LAT(3), .AW(12), .DW(16)) dut3 (
      .clk(clk), .rst(rst), .run(run), .halt_req(halt_req), .instr(instr), .result(result),
      .ra(ra), .pc(pc), .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr),
      .ldr_data(ldr_data), .phase(phase3), .address(address3), .wren(wren3), .data(data3),
      .ir_load(irLoad3), .pc_inc(pcInc3), .rf_we(rfWe3), .ldr_ack(ldrAck3), .halted(halted3)
   );

   assign obs1 = {phase1, address1, wren1, data1, irLoad1, pcInc1, rfWe1, ldrAck1, halted1};
   assign obs3 = {phase3, address3, wren3, data3, irLoad3, pcInc3, rfWe3, ldrAck3, halted3};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected bus/strobe values for one cycle, straight from the phase/bus table.
   function automatic outs_t model(input int ph, input bit lastIf, input logic [15:0] ins,
                                   input logic [15:0] res, input logic [15:0] rav,
                                   input logic [11:0] pcv, input logic lreq, input logic lwe,
                                   input logic [11:0] laddr, input logic [15:0] ldat);
      outs_t e;
      e = '0;
      e.address = pcv;
      e.phase   = 3'(ph);
      case (ph)
         PH_IDLE: e.halted = 1'b1;
         PH_IF:   e.irLoad = lastIf;
         PH_MEM: begin
            if (ins[15:14] == 2'b00) begin
               e.address = res[11:0];
            end else if (ins[15:14] == 2'b01) begin
               e.address = res[11:0];
               e.wren    = 1'b1;
               e.data    = rav;
            end
         end
         default: begin
            e.pcInc = 1'b1;
            e.rfWe  = (ins[15:14] != 2'b01);
         end
      endcase
      if ((ph == PH_IDLE || ph == PH_WB) && lreq) begin
         e.address = laddr;
         e.wren    = lwe;
         e.data    = ldat;
         e.ldrAck  = 1'b1;
      end
      return e;
   endfunction

   task automatic applyReset();
      @(negedge clk);
      rst = 1'b1; run = 1'b0; ldr_req = 1'b0; halt_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Runs n instructions from IDLE on the selected instance, halting after the last WB,
   // and records observed and expected outputs for every cycle of the plan.
   task automatic runProgram(input int sel, input int n);
      int    lat;
      int    memCycles;
      step_t plan [$];
      step_t st;
      lat = (sel == 1) ? 3 : 1;
      obsQ.delete();
      expQ.delete();
      plan.push_back('{PH_IDLE, 0, 1'b0});
      for (int k = 0; k < n; k++) begin
         for (int c = 0; c < lat; c++) plan.push_back('{PH_IF, k, (c == lat - 1)});
         memCycles = (pInstr[k][15:14] == 2'b00) ? lat : 1;
         for (int c = 0; c < memCycles; c++) plan.push_back('{PH_MEM, k, 1'b0});
         plan.push_back('{PH_WB, k, 1'b0});
      end
      plan.push_back('{PH_IDLE, n - 1, 1'b0});
      foreach (plan[s]) begin
         st = plan[s];
         @(negedge clk);
         instr  = pInstr[st.idx];
         result = pResult[st.idx];
         ra     = pRa[st.idx];
         pc     = pPc[st.idx];
         if (s == 0) run = 1'b1;
         else if (st.ph == PH_IDLE) run = 1'b0;
         else run = 1'($urandom_range(0, 1));
         if (st.ph == PH_WB) halt_req = (st.idx == n - 1);
         else if (haltMode == 1) halt_req = 1'b1;
         else halt_req = 1'($urandom_range(0, 1));
         if (ldrMode == 0) ldr_req = 1'b0;
         else if (ldrMode == 2) ldr_req = 1'b1;
         else ldr_req = 1'($urandom_range(0, 1));
         ldr_we   = 1'($urandom_range(0, 1));
         ldr_addr = 12'($urandom);
         ldr_data = 16'($urandom);
         #1;
         expQ.push_back(model(st.ph, st.lastIf, instr, result, ra, pc, ldr_req, ldr_we,
                              ldr_addr, ldr_data));
         obsQ.push_back((sel == 1) ? obs3 : obs1);
      end
      run = 1'b0; ldr_req = 1'b0; halt_req = 1'b0;
   endtask

   task automatic randomProg(input int n);
      for (int k = 0; k < n; k++) begin
         pInstr[k] = 16'($urandom); pResult[k] = 16'($urandom);
         pRa[k] = 16'($urandom); pPc[k] = 12'($urandom);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; run = 1'b0; halt_req = 1'b0; ldr_req = 1'b0; ldr_we = 1'b0;
      instr = '0; result = '0; ra = '0; pc = '0; ldr_addr = '0; ldr_data = '0;
      @(negedge clk);
      run = 1'b1; ldr_req = 1'b1; ldr_we = 1'b1;
      #1;
      checks++;
      if ({phase1, wren1, irLoad1, pcInc1, rfWe1, ldrAck1, halted1} !== 9'b100_00000_1) begin
         errors++;
         $display("FAIL reset_dut1: got %b expected %b",
                  {phase1, wren1, irLoad1, pcInc1, rfWe1, ldrAck1, halted1}, 9'b100_00000_1);
      end
      checks++;
      if ({phase3, wren3, irLoad3, pcInc3, rfWe3, ldrAck3, halted3} !== 9'b100_00000_1) begin
         errors++;
         $display("FAIL reset_dut3: got %b expected %b",
                  {phase3, wren3, irLoad3, pcInc3, rfWe3, ldrAck3, halted3}, 9'b100_00000_1);
      end
      @(negedge clk);
      rst = 1'b0; run = 1'b0; ldr_req = 1'b0;
   endtask

   task automatic test_nonmem();
      applyReset();
      randomProg(2);
      pInstr[0] = 16'h8000; pInstr[1] = 16'hC123;
      runProgram(0, 2);
      foreach (expQ[i]) begin
         checks++;
         if (obsQ[i] !== expQ[i]) begin
            errors++;
            $display("FAIL nonmem cycle %0d: got %h expected %h", i, obsQ[i], expQ[i]);
         end
      end
      checks++;
      if ({obsQ[0].phase, obsQ[1].phase, obsQ[2].phase, obsQ[3].phase, obsQ[4].phase}
          !== 15'b100_000_001_010_000) begin
         errors++;
         $display("FAIL nonmem_phase_seq: got %b expected %b",
                  {obsQ[0].phase, obsQ[1].phase, obsQ[2].phase, obsQ[3].phase, obsQ[4].phase},
                  15'b100_000_001_010_000);
      end
   endtask

   task automatic test_store();
      int wrenCount;
      applyReset();
      ldrMode = 0;
      pInstr[0] = 16'h4000; pResult[0] = 16'h0123; pRa[0] = 16'hBEEF; pPc[0] = 12'h010;
      runProgram(0, 1);
      foreach (expQ[i]) begin
         checks++;
         if (obsQ[i] !== expQ[i]) begin
            errors++;
            $display("FAIL store cycle %0d: got %h expected %h", i, obsQ[i], expQ[i]);
         end
      end
      wrenCount = 0;
      foreach (obsQ[i]) if (obsQ[i].wren === 1'b1) wrenCount++;
      checks++;
      if (wrenCount != 1 || obsQ[2].address !== 12'h123 || obsQ[2].data !== 16'hBEEF
          || obsQ[3].rfWe !== 1'b0) begin
         errors++;
         $display("FAIL store_bus: got wren_cycles=%0d addr=%h data=%h rf_we=%b expected 1 123 beef 0",
                  wrenCount, obsQ[2].address, obsQ[2].data, obsQ[3].rfWe);
      end
      ldrMode = 1;
   endtask

   task automatic test_load_lat3();
      applyReset();
      ldrMode = 0;
      pInstr[0] = 16'h0000; pResult[0] = 16'h0FFF; pRa[0] = 16'h1234; pPc[0] = 12'h020;
      runProgram(1, 1);
      foreach (expQ[i]) begin
         checks++;
         if (obsQ[i] !== expQ[i]) begin
            errors++;
            $display("FAIL load cycle %0d: got %h expected %h", i, obsQ[i], expQ[i]);
         end
      end
      checks++;
      if (obsQ.size() != 9 || obsQ[3].phase !== 3'b000 || obsQ[6].phase !== 3'b001
          || obsQ[6].address !== 12'hFFF || obsQ[6].wren !== 1'b0 || obsQ[7].phase !== 3'b010) begin
         errors++;
         $display("FAIL load_hold: got len=%0d ph3=%b ph6=%b addr6=%h ph7=%b expected 9 000 001 fff 010",
                  obsQ.size(), obsQ[3].phase, obsQ[6].phase, obsQ[6].address, obsQ[7].phase);
      end
      ldrMode = 1;
   endtask

   task automatic test_loader_idle();
      int firstAck;
      applyReset();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 12'(i); ldr_data = 16'hA5A0 + 16'(i);
         #1;
         checks++;
         if ({ldrAck1, wren1, address1, data1} !== {1'b1, 1'b1, 12'(i), 16'hA5A0 + 16'(i)}) begin
            errors++;
            $display("FAIL loader_idle_%0d: got ack=%b wren=%b addr=%h data=%h expected 1 1 %h %h",
                     i, ldrAck1, wren1, address1, data1, 12'(i), 16'hA5A0 + 16'(i));
         end
      end
      ldr_req = 1'b0;
      randomProg(1);
      ldrMode = 2;
      runProgram(1, 1);
      foreach (expQ[i]) begin
         checks++;
         if (obsQ[i] !== expQ[i]) begin
            errors++;
            $display("FAIL loader_held cycle %0d: got %h expected %h", i, obsQ[i], expQ[i]);
         end
      end
      firstAck = -1;
      for (int i = 1; i < obsQ.size(); i++) if (firstAck < 0 && obsQ[i].ldrAck === 1'b1) firstAck = i;
      checks++;
      if (firstAck != ((pInstr[0][15:14] == 2'b00) ? 7 : 5)) begin
         errors++;
         $display("FAIL loader_wait: got first ack at %0d expected %0d", firstAck,
                  (pInstr[0][15:14] == 2'b00) ? 7 : 5);
      end
      ldrMode = 1;
   endtask

   task automatic test_halt_resume();
      applyReset();
      haltMode = 1;
      randomProg(2);
      runProgram(1, 2);
      foreach (expQ[i]) begin
         checks++;
         if (obsQ[i] !== expQ[i]) begin
            errors++;
            $display("FAIL halt cycle %0d: got %h expected %h", i, obsQ[i], expQ[i]);
         end
      end
      haltMode = 0;
      randomProg(1);
      runProgram(1, 1);
      foreach (expQ[i]) begin
         checks++;
         if (obsQ[i] !== expQ[i]) begin
            errors++;
            $display("FAIL resume cycle %0d: got %h expected %h", i, obsQ[i], expQ[i]);
         end
      end
   endtask

   task automatic test_back_to_back_random();
      int sel, n;
      for (int it = 0; it < 12; it++) begin
         applyReset();
         sel = $urandom_range(0, 1);
         n = $urandom_range(1, 3);
         ldrMode = $urandom_range(0, 2);
         randomProg(n);
         runProgram(sel, n);
         foreach (expQ[i]) begin
            checks++;
            if (obsQ[i] !== expQ[i]) begin
               errors++;
               $display("FAIL random it%0d sel%0d cycle %0d: got %h expected %h",
                        it, sel, i, obsQ[i], expQ[i]);
            end
         end
      end
      ldrMode = 1;
   endtask

   task automatic test_reset_mid_store();
      applyReset();
      instr = 16'h4000; result = 16'h0123; ra = 16'hBEEF; pc = 12'h040; ldr_req = 1'b0;
      @(negedge clk); run = 1'b1;
      @(negedge clk); run = 1'b0;
      @(negedge clk); rst = 1'b1;
      #1;
      checks++;
      if ({phase1, wren1, pcInc1, rfWe1, irLoad1} !== 7'b001_0000) begin
         errors++;
         $display("FAIL reset_mid_store: got %b expected %b",
                  {phase1, wren1, pcInc1, rfWe1, irLoad1}, 7'b001_0000);
      end
      @(negedge clk); rst = 1'b0;
      #1;
      checks++;
      if ({phase1, halted1, wren1} !== 5'b100_1_0) begin
         errors++;
         $display("FAIL after_reset_store: got %b expected %b", {phase1, halted1, wren1}, 5'b100_1_0);
      end
   endtask

   initial begin
      ldrMode = 1;
      haltMode = 0;
      test_reset();
      test_nonmem();
      test_store();
      test_load_lat3();
      test_loader_idle();
      test_halt_resume();
      test_back_to_back_random();
      test_reset_mid_store();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
